// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg
// Shared CPU datapath definitions: write-mode encodings and default width.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    WM_LOAD  = 2'b00,
    WM_CLEAR = 2'b01,
    WM_INC   = 2'b10,
    WM_SHL   = 2'b11
  } wr_mode_e;

endpackage

`default_nettype wire

// File: rtl/reg_bank_next.sv
// ============================================================================
// reg_bank_next
// Combinational next-value and wrap computation for the register-bank write port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_bank_next
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  wr_mode_e          i_mode,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_next,
  output logic              o_wrap
);

  always_comb begin
    o_next = i_old;
    o_wrap = 1'b0;
    case (i_mode)
      WM_LOAD:  o_next = i_wr_data;
      WM_CLEAR: o_next = '0;
      WM_INC: begin
        o_next = i_old + DATA_W'(1);
        o_wrap = &i_old;
      end
      WM_SHL:   o_next = {i_old[DATA_W-2:0], 1'b0};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_reg_bank.sv
// ============================================================================
// cpu_reg_bank
// Register bank with one multi-mode write port and two forwarded, registered read ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_reg_bank
  import cpu_pkg::*;
#(
  parameter  int DATA_W  = CPU_DATA_W,
  parameter  int NREGS   = 8,
  parameter  int ZERO_R0 = 0,
  localparam int ADDR_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_mode,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              ovf
);

  localparam logic c_ZERO_R0 = (ZERO_R0 != 0);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_rd_a;
  logic [DATA_W-1:0] r_rd_b;
  logic              r_ovf;

  logic [DATA_W-1:0] w_next;
  logic              w_wrap;
  logic              w_do_write;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  reg_bank_next #(
    .DATA_W (DATA_W)
  ) u_next (
    .i_mode    (wr_mode_e'(wr_mode)),
    .i_old     (r_regs[wr_addr]),
    .i_wr_data (wr_data),
    .o_next    (w_next),
    .o_wrap    (w_wrap)
  );

  // A write to a hardwired-zero R0 is suppressed entirely, including its ovf.
  assign w_do_write = wr_en && !(c_ZERO_R0 && (wr_addr == '0));

  always_comb begin
    w_rd_a = r_regs[rd_addr_a];
    w_rd_b = r_regs[rd_addr_b];
    if (w_do_write && (wr_addr == rd_addr_a)) w_rd_a = w_next;
    if (w_do_write && (wr_addr == rd_addr_b)) w_rd_b = w_next;
    if (c_ZERO_R0 && (rd_addr_a == '0)) w_rd_a = '0;
    if (c_ZERO_R0 && (rd_addr_b == '0)) w_rd_b = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_rd_a <= '0;
      r_rd_b <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_do_write) r_regs[wr_addr] <= w_next;
      r_rd_a <= w_rd_a;
      r_rd_b <= w_rd_b;
      r_ovf  <= w_do_write && w_wrap;
    end
  end

  assign rd_data_a = r_rd_a;
  assign rd_data_b = r_rd_b;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: doc/cpu_reg_bank.md
Name: cpu_reg_bank

Overview:
- Parametrised successor to the single load-enabled datapath register (regC): a bank of NREGS registers, each DATA_W bits wide.
- One write port supports four write modes: LOAD, CLEAR, INC, SHL.
- Two registered read ports with write-to-read forwarding.
- Sits in the CPU datapath between the ALU result bus and the operand latches, replacing the discrete per-register instances.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- NREGS, 8, number of registers; must be a power of two, minimum 2.
- ADDR_W, $clog2(NREGS), address width; derived, not overridden.
- ZERO_R0, 0, when 1, register 0 reads as zero and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe; sampled on the rising clk edge.
- wr_mode  input  2  00 LOAD, 01 CLEAR, 10 INC, 11 SHL.
- wr_addr  input  ADDR_W  target register.
- wr_data  input  DATA_W  load value; ignored for CLEAR, INC and SHL.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_data_a  output  DATA_W  read port A data; registered.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_b  output  DATA_W  read port B data; registered.
- ovf  output  1  pulses for one cycle when an INC wraps from all-ones to zero.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Reset: all registers, rd_data_a, rd_data_b and ovf go to 0 on the first edge with rst=1. While rst=1, wr_en is ignored.
- Write, on an edge with wr_en=1 and rst=0, by wr_mode:
  - LOAD: R[wr_addr] <= wr_data.
  - CLEAR: R[wr_addr] <= 0.
  - INC: R[wr_addr] <= R[wr_addr]+1, modulo 2^DATA_W. ovf <= 1 iff the old value was all-ones.
  - SHL: R[wr_addr] <= {R[wr_addr][DATA_W-2:0], 1'b0}. The MSB is discarded and ovf is not affected.
- ovf is 0 on every edge that does not perform a wrapping INC.
- wr_en=0: no register changes.
- Read latency is 1 cycle: rd_data_x at edge N+1 reflects rd_addr_x sampled at edge N.
- Forwarding: if at edge N wr_en=1 and wr_addr==rd_addr_x, rd_data_x takes the newly computed value (post-mode result), not the old contents.
- Both ports may address the same register, and both may forward simultaneously.
- ZERO_R0=1:
  - Writes to address 0 are dropped.
  - Reads of 0 return 0 and do not forward.
  - An INC to address 0 does not raise ovf.
- Reset mid-operation: a write coincident with rst=1 is lost. Read outputs reset to 0 regardless of addresses.
- Out-of-range addresses cannot occur, since NREGS is a power of two.

Decomposition:
- Shared package cpu_pkg holds:
  - the wr_mode encodings (WM_LOAD, WM_CLEAR, WM_INC, WM_SHL);
  - the default DATA_W.
- One sub-module, reg_bank_next: purely combinational next-value/ovf computation from (mode, old value, wr_data).
  - It is instantiated once at the write port.
  - The forwarding mux reuses its output.

Test Plan:
- Reset and LOAD:
  - Stimulus: assert rst for 2 cycles, then LOAD R3=32'h00f430fe, then read A=3 on the next cycle.
  - Required response: rd_data_a=0 after reset; rd_data_a=32'h00f430fe one cycle after the read address is presented.
- Hold when disabled:
  - Stimulus: after R3=32'h00f430fe, present wr_en=0 with wr_data=32'h12340fe6 and wr_addr=3 for 3 cycles.
  - Required response: reads of R3 return 32'h00f430fe throughout.
- INC wrap:
  - Stimulus: LOAD R5=32'hffffffff, then INC R5.
  - Required response: ovf=1 for exactly one cycle and R5 reads 0. A second INC gives R5=1 with ovf=0.
- SHL and CLEAR:
  - Stimulus: LOAD R2=32'h80000001, SHL R2, then CLEAR R2.
  - Required response: reads of R2 return 32'h00000002, then 0; ovf stays 0.
- Forwarding on both ports:
  - Stimulus: same cycle, LOAD R1=32'hdeadbeef with rd_addr_a=rd_addr_b=1.
  - Required response: both ports return 32'hdeadbeef next cycle. Repeat with INC R1: both return 32'hdeadbef0.
- ZERO_R0=1 and reset collision:
  - Stimulus (ZERO_R0=1): LOAD R0=32'h1234 while reading R0.
  - Required response: reads of R0 return 0.
  - Stimulus: LOAD R4=32'h55 coincident with rst=1.
  - Required response: R4 reads 0 after reset.
